// File: rtl/clic_gateway.sv
// Per-source interrupt gateway feeding the CLIC clicintip hardware set/clear port.
// Optional CLIC_GATEWAY_SYNC_EN adds a 2-flop input synchroniser per source.
module clic_gateway #(
  parameter int unsigned N_SOURCE = 256,
  parameter int unsigned IDW      = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_SOURCE-1:0]      intr_src_i,
  input  logic [N_SOURCE-1:0][1:0] trig_i,
  input  logic [N_SOURCE-1:0]      ip_q_i,
  output logic [N_SOURCE-1:0]      ip_de_o,
  output logic [N_SOURCE-1:0]      ip_d_o,
  input  logic                     claim_valid_i,
  input  logic [IDW-1:0]           claim_id_i,
  output logic                     claim_ready_o
);

  typedef enum logic [0:0] {StIdle, StClr} state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [N_SOURCE-1:0] src_s, src_q;
  logic                primed_q;

  // clicintip readback is only observed, never used for gating decisions.
  logic unused_ip;
  assign unused_ip = ^ip_q_i;

`ifdef CLIC_GATEWAY_SYNC_EN
  logic [N_SOURCE-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= intr_src_i;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = intr_src_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_q    <= '0;
      primed_q <= 1'b0;
      state_q  <= StIdle;
      id_q     <= '0;
    end else begin
      src_q    <= src_s;
      primed_q <= 1'b1;
      state_q  <= state_d;
      id_q     <= id_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    claim_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (claim_valid_i) begin
          id_d    = claim_id_i;
          state_d = StClr;
        end
      end
      StClr: begin
        claim_ready_o = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    logic act, act_prev, edge_hit;
    act      = 1'b0;
    act_prev = 1'b0;
    edge_hit = 1'b0;
    ip_de_o  = '0;
    ip_d_o   = '0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      act      = src_s[i] ^ trig_i[i][1];
      act_prev = src_q[i] ^ trig_i[i][1];
      edge_hit = primed_q & act & ~act_prev;
      if (!trig_i[i][0]) begin
        ip_de_o[i] = primed_q;
        ip_d_o[i]  = act;
      end else if (edge_hit) begin
        // A fresh edge beats a concurrent claim clear so the new request is kept.
        ip_de_o[i] = 1'b1;
        ip_d_o[i]  = 1'b1;
      end else if (state_q == StClr && id_q == IDW'(i)) begin
        // Out-of-range ids never match any index, so they only get acknowledged.
        ip_de_o[i] = 1'b1;
        ip_d_o[i]  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clic_gateway.sv
// Directed, table-driven bench for clic_gateway (N_SOURCE=200) with a clicintip register model.
module tb_clic_gateway;

  localparam int unsigned NS  = 200;
  localparam int unsigned IDW = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NS-1:0]      intr_src;
  logic [NS-1:0][1:0] trig;
  logic [NS-1:0]      ip, de, d;
  logic               cv, rdy;
  logic [IDW-1:0]     cid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clic_gateway #(.N_SOURCE(NS)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .intr_src_i   (intr_src),
    .trig_i       (trig),
    .ip_q_i       (ip),
    .ip_de_o      (de),
    .ip_d_o       (d),
    .claim_valid_i(cv),
    .claim_id_i   (cid),
    .claim_ready_o(rdy)
  );

  // clicintip model: hardware write port only.
  always_ff @(posedge clk) begin
    if (!rst_n) ip <= '0;
    else        ip <= (ip & ~de) | (d & de);
  end

  typedef struct {
    logic [7:0] src;
    logic       cv;
    logic [7:0] cid;
    logic [7:0] de;
    logic [7:0] d;
    logic       rdy;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] src, input logic v, input logic [7:0] id);
    intr_src      = '0;
    intr_src[7:0] = src;
    cv            = v;
    cid           = id;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Sources 2,3 edge active-high, 5 level, 7 edge active-low; all others edge active-high.
    for (int i = 0; i < NS; i++) trig[i] = 2'b01;
    trig[5] = 2'b00;
    trig[7] = 2'b11;

    vecs[0]  = '{8'h88, 1'b0, 8'd0, 8'h00, 8'h00, 1'b0}; // line 3 high through reset
    vecs[1]  = '{8'h88, 1'b0, 8'd0, 8'h20, 8'h00, 1'b0};
    vecs[2]  = '{8'h80, 1'b0, 8'd0, 8'h20, 8'h00, 1'b0};
    vecs[3]  = '{8'h88, 1'b0, 8'd0, 8'h28, 8'h08, 1'b0}; // rising edge on 3
    vecs[4]  = '{8'h88, 1'b0, 8'd0, 8'h20, 8'h00, 1'b0};
    vecs[5]  = '{8'hA8, 1'b0, 8'd0, 8'h20, 8'h20, 1'b0}; // level 5 follows
    vecs[6]  = '{8'hA8, 1'b0, 8'd0, 8'h20, 8'h20, 1'b0};
    vecs[7]  = '{8'h88, 1'b0, 8'd0, 8'h20, 8'h00, 1'b0};
    vecs[8]  = '{8'h08, 1'b0, 8'd0, 8'hA0, 8'h80, 1'b0}; // active-low 7 falls
    vecs[9]  = '{8'h08, 1'b1, 8'd7, 8'h20, 8'h00, 1'b0};
    vecs[10] = '{8'h08, 1'b1, 8'd7, 8'hA0, 8'h00, 1'b1}; // clear 7
    vecs[11] = '{8'h08, 1'b0, 8'd0, 8'h20, 8'h00, 1'b0};
    vecs[12] = '{8'h08, 1'b1, 8'd2, 8'h20, 8'h00, 1'b0};
    vecs[13] = '{8'h0C, 1'b1, 8'd2, 8'h24, 8'h04, 1'b1}; // edge beats clear
    vecs[14] = '{8'h0C, 1'b0, 8'd0, 8'h20, 8'h00, 1'b0};
    vecs[15] = '{8'h0C, 1'b1, 8'd5, 8'h20, 8'h00, 1'b0};
    vecs[16] = '{8'h0C, 1'b1, 8'd5, 8'h20, 8'h00, 1'b1}; // claim on level: no clear
    vecs[17] = '{8'h0C, 1'b1, 8'd3, 8'h20, 8'h00, 1'b0};
    vecs[18] = '{8'h0C, 1'b1, 8'd3, 8'h28, 8'h00, 1'b1}; // clear 3
    vecs[19] = '{8'h0C, 1'b0, 8'd0, 8'h20, 8'h00, 1'b0};

    rst_n = 1'b0;
    drive(8'h88, 1'b0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset de", {31'd0, |de}, 32'd0);
    check("reset d", {31'd0, |d}, 32'd0);
    check("reset ready", {31'd0, rdy}, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      drive(vecs[k].src, vecs[k].cv, vecs[k].cid);
      #1;
      check($sformatf("v%0d de", k), {24'd0, de[7:0]}, {24'd0, vecs[k].de});
      check($sformatf("v%0d d", k), {24'd0, d[7:0]}, {24'd0, vecs[k].d});
      check($sformatf("v%0d de_hi", k), {31'd0, |de[NS-1:8]}, 32'd0);
      check($sformatf("v%0d ready", k), {31'd0, rdy}, {31'd0, vecs[k].rdy});
      next_cycle();
    end
    check("ip2 kept", {31'd0, ip[2]}, 32'd1);
    check("ip3 cleared", {31'd0, ip[3]}, 32'd0);
    check("ip7 cleared", {31'd0, ip[7]}, 32'd0);

    // Out-of-range claim: acknowledged, no writes anywhere.
    trig[5] = 2'b01;
    drive(8'h0C, 1'b1, 8'd250);
    #1;
    check("oor idle ready", {31'd0, rdy}, 32'd0);
    check("oor idle de", {31'd0, |de}, 32'd0);
    next_cycle();
    check("oor ready", {31'd0, rdy}, 32'd1);
    check("oor de", {31'd0, |de}, 32'd0);
    drive(8'h0C, 1'b0, 8'd0);
    next_cycle();
    check("oor done", {31'd0, rdy}, 32'd0);

    // Reset landing on the CLR cycle, then a fresh claim.
    drive(8'h0C, 1'b1, 8'd3);
    next_cycle();
    check("mid clr ready", {31'd0, rdy}, 32'd1);
    rst_n = 1'b0;
    cv    = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("post rst ready", {31'd0, rdy}, 32'd0);
    check("post rst de", {31'd0, |de}, 32'd0);
    next_cycle();
    drive(8'h0C, 1'b1, 8'd7);
    #1;
    check("reclaim idle", {31'd0, rdy}, 32'd0);
    next_cycle();
    check("reclaim ready", {31'd0, rdy}, 32'd1);
    check("reclaim de", {24'd0, de[7:0]}, 32'h80);
    check("reclaim d", {31'd0, |d}, 32'd0);
    check("reclaim de_hi", {31'd0, |de[NS-1:8]}, 32'd0);
    drive(8'h0C, 1'b0, 8'd0);
    next_cycle();
    check("reclaim done", {31'd0, rdy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
